// File: rtl/demo_qsys_ram_streamer_pkg.sv
// Shared types and defaults for the on-chip RAM streamer.
// Defines the FSM state encoding and the default RAM geometry.
package demo_qsys_ram_streamer_pkg;

    localparam int MAX_WORDS  = 1024;
    localparam int DEF_ADDR_W = $clog2(MAX_WORDS);
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/demo_qsys_ram_stream_fifo.sv
// Small synchronous FIFO carrying {data, sop, eop} between the RAM return path and the stream port.
// Read data is forced to zero while empty so the stream outputs idle low.
module demo_qsys_ram_stream_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   count_q;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push)   wr_q <= wr_q + PTR_W'(1);
            if (pop_ok) rd_q <= rd_q + PTR_W'(1);
            if (push && !pop_ok)      count_q <= count_q + (PTR_W+1)'(1);
            else if (!push && pop_ok) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    // Storage is datapath only; pointers and count carry the reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/demo_qsys_ram_streamer.sv
// Avalon-MM read master over the on-chip RAM that replays a wrapped address range
// as a single Avalon-ST packet with backpressure and abort.
module demo_qsys_ram_streamer
    import demo_qsys_ram_streamer_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_clken,
    output logic                ram_write,
    output logic [DATA_W/8-1:0] ram_byteenable,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_startofpacket,
    output logic                out_endofpacket
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [CNT_W-1:0]        remaining_q;
    logic                    first_q, busy_q, done_q, clken_q;
    logic [READ_LATENCY-1:0] inf_vld_q, inf_sop_q, inf_eop_q;

    logic [FCNT_W-1:0]       fifo_count;
    logic                    fifo_empty;
    logic [DATA_W+1:0]       fifo_rd;
    logic                    issue, pop, eop_pop, abort_act, push;
    int                      used;

    // Credit = words buffered plus words still in the RAM pipeline.
    always_comb begin
        used = int'(fifo_count);
        for (int i = 0; i < READ_LATENCY; i++) used = used + int'(inf_vld_q[i]);
    end

    assign pop       = !fifo_empty && out_ready;
    assign eop_pop   = pop && fifo_rd[0];
    assign abort_act = abort && (state_q != ST_IDLE) && !eop_pop;
    assign issue     = (state_q == ST_READ) && (remaining_q != '0) &&
                       (used < FIFO_DEPTH) && !abort;
    assign push      = inf_vld_q[READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clken_q     <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_READ;
                            busy_q      <= 1'b1;
                            addr_q      <= base_addr;
                            remaining_q <= (word_count > MAX_CNT) ? MAX_CNT : word_count;
                            first_q     <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (abort_act) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (issue) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        first_q     <= 1'b0;
                        if (remaining_q == CNT_W'(1)) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort_act || eop_pop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Return pipeline: a read issued now lands in the FIFO READ_LATENCY edges later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inf_vld_q <= '0;
            inf_sop_q <= '0;
            inf_eop_q <= '0;
        end else if (abort_act) begin
            inf_vld_q <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                inf_vld_q[i] <= inf_vld_q[i-1];
                inf_sop_q[i] <= inf_sop_q[i-1];
                inf_eop_q[i] <= inf_eop_q[i-1];
            end
            inf_vld_q[0] <= issue;
            inf_sop_q[0] <= first_q;
            inf_eop_q[0] <= (remaining_q == CNT_W'(1));
        end
    end

    demo_qsys_ram_stream_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({ram_readdata, inf_sop_q[READ_LATENCY-1], inf_eop_q[READ_LATENCY-1]}),
        .pop       (pop),
        .flush     (abort_act),
        .rd_data   (fifo_rd),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign busy              = busy_q;
    assign done              = done_q;
    assign ram_address       = addr_q;
    assign ram_chipselect    = issue;
    assign ram_clken         = clken_q;
    assign ram_write         = 1'b0;
    assign ram_byteenable    = '1;
    assign out_valid         = !fifo_empty;
    assign out_data          = fifo_rd[DATA_W+1:2];
    assign out_startofpacket = fifo_rd[1];
    assign out_endofpacket   = fifo_rd[0];

endmodule

// File: tb/tb_demo_qsys_ram_streamer.sv
// Scoreboard bench for demo_qsys_ram_streamer with a behavioural 1024x32 RAM (word[i]=i).
`timescale 1ns/1ps
module tb_demo_qsys_ram_streamer;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            out_ready = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW:0]     word_count = '0;
    logic            busy, done, ram_chipselect, ram_clken, ram_write;
    logic            out_valid, out_sop, out_eop;
    logic [AW-1:0]   ram_address;
    logic [DW/8-1:0] ram_byteenable;
    logic [DW-1:0]   ram_readdata, out_data;

    logic [DW-1:0]   mem [1024];
    logic [DW+1:0]   sb_q [$];
    logic [AW-1:0]   addr_q [$];
    logic [DW+1:0]   exp_w, hold_prev;
    logic [AW-1:0]   exp_a;
    logic            stall_prev = 1'b0;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              occ = 0;
    int              eop_cyc = -10;

    demo_qsys_ram_streamer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .ram_address       (ram_address),
        .ram_chipselect    (ram_chipselect),
        .ram_clken         (ram_clken),
        .ram_write         (ram_write),
        .ram_byteenable    (ram_byteenable),
        .ram_readdata      (ram_readdata),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) ram_readdata <= mem[ram_address];
    end

    // Monitor: address order, credit limit, stall stability and stream scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            occ = 0;
            stall_prev = 1'b0;
        end else begin
            if (ram_chipselect) begin
                checks++;
                if (occ >= DEPTH) begin
                    errors++;
                    $display("FAIL credit: chipselect with occupancy %0d, limit %0d", occ, DEPTH);
                end
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read of %0d, none required", ram_address);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (ram_address !== exp_a) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d required %0d", ram_address, exp_a);
                    end
                end
            end
            if (stall_prev && out_valid) begin
                checks++;
                if ({out_data, out_sop, out_eop} !== hold_prev) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", {out_data, out_sop, out_eop}, hold_prev);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected word %h, none required", out_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    if ({out_data, out_sop, out_eop} !== exp_w) begin
                        errors++;
                        $display("FAIL stream: got data %0d sop %b eop %b required data %0d sop %b eop %b",
                                 out_data, out_sop, out_eop, exp_w[DW+1:2], exp_w[1], exp_w[0]);
                    end
                end
                if (out_eop) eop_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            hold_prev  = {out_data, out_sop, out_eop};
            if (abort && busy) occ = 0;
            else occ = occ + int'(ram_chipselect) - int'(out_valid && out_ready);
        end
    end

    task automatic start_xfer(input int base, input int count);
        int n;
        int a;
        n = (count > 1024) ? 1024 : count;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % 1024;
            sb_q.push_back({mem[a], (k == 0), (k == n - 1)});
            addr_q.push_back(a[AW-1:0]);
        end
        base_addr  = base[AW-1:0];
        word_count = count[AW:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, out_valid, out_sop, out_eop, ram_chipselect, ram_clken} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy, done, out_valid, out_sop, out_eop, ram_chipselect, ram_clken});
        end
        checks++;
        if (out_data !== '0 || ram_address !== '0) begin
            errors++;
            $display("FAIL reset_data: got data %h addr %0d required 0 0", out_data, ram_address);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_clken !== 1'b1) begin
            errors++;
            $display("FAIL clken: got %b required 1", ram_clken);
        end
        checks++;
        if (ram_write !== 1'b0 || ram_byteenable !== 4'hf) begin
            errors++;
            $display("FAIL ram_const: got write %b be %h required 0 f", ram_write, ram_byteenable);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy %b valid %b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat, first_cyc, n;
        out_ready = 1'b1;
        start_xfer(0, 8);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        first_cyc = cyc;
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL first_latency: got %0d required 3", lat);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_active: got %b required 1", busy);
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL basic_done: got timeout required done pulse");
        end else begin
            checks++;
            if (cyc - first_cyc != 8) begin
                errors++;
                $display("FAIL throughput: got %0d cycles required 8", cyc - first_cyc);
            end
            checks++;
            if (eop_cyc != cyc - 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_timing: got eop_cyc %0d busy %b required %0d 0", eop_cyc, busy, cyc - 1);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d words left required 0", sb_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b required 0", done);
        end
    endtask

    task automatic test_wrap();
        int n;
        out_ready = 1'b1;
        start_xfer(1020, 6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        checks++;
        if (!done || sb_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: got done %b words left %0d reads left %0d required 1 0 0",
                     done, sb_q.size(), addr_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_xfer(100, 16);
        for (n = 0; n < 300; n++) begin
            out_ready = (n % 3 == 0);
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done || sb_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure: got done %b words left %0d required 1 0", done, sb_q.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_single_and_zero();
        int n;
        out_ready = 1'b1;
        start_xfer(77, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checks++;
        if (!done || sb_q.size() != 0) begin
            errors++;
            $display("FAIL single: got done %b words left %0d required 1 0", done, sb_q.size());
        end
        start_xfer(3, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done %b busy %b valid %b required 1 0 0", done, busy, out_valid);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_quiet: got done %b busy %b valid %b required 0 0 0", done, busy, out_valid);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        out_ready = 1'b0;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got done %b busy %b required 0 0", done, busy);
        end
        start_xfer(200, 100);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got valid %b required 1", out_valid);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: got valid %b done %b busy %b required 0 1 0", out_valid, done, busy);
        end
        sb_q.delete();
        addr_q.delete();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: got done %b valid %b required 0 0", done, out_valid);
        end
        out_ready = 1'b1;
        start_xfer(5, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checks++;
        if (!done || sb_q.size() != 0) begin
            errors++;
            $display("FAIL restart: got done %b words left %0d required 1 0", done, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n, n_done;
        out_ready = 1'b0;
        start_xfer(300, 50);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got valid %b required 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ram_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got valid %b busy %b cs %b required 0 0 0", out_valid, busy, ram_chipselect);
        end
        sb_q.delete();
        addr_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++;
        if (n_done != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses valid %b required 0 0", n_done, out_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_single_and_zero();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demo_qsys_ram_streamer.md
Name: demo_qsys_ram_streamer

Overview:
- Avalon-MM read master sitting directly upstream of the on-chip RAM s1 slave: 1024 x 32, single-port, read latency 1.
- On a start command it reads `word_count` consecutive words from `base_addr`, wrapping at the top of the RAM.
- Emits the words as one Avalon-ST packet with backpressure.
- Feeds the HPS-side demo datapath. Replaces ad-hoc software polling of RAM contents.

Parameters:
ADDR_W, 10, RAM word-address width (1024 words)
DATA_W, 32, RAM / stream data width
FIFO_DEPTH, 4, output buffer depth in words, power of 2, >= READ_LATENCY+1
READ_LATENCY, 1, RAM cycles from address issue to readdata valid

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_W  first word address, sampled with start
word_count  in  ADDR_W+1  words to read (0..1024), sampled with start
abort  in  1  one-cycle pulse; cancels an active transfer
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion/abort pulse
ram_address  out  ADDR_W  to RAM address
ram_chipselect  out  1  high on read-issue cycles only
ram_clken  out  1  constant 1 out of reset
ram_write  out  1  constant 0
ram_byteenable  out  DATA_W/8  constant all-ones
ram_readdata  in  DATA_W  RAM q
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  sink ready
out_startofpacket  out  1  first word of packet
out_endofpacket  out  1  last word of packet

Behaviour:
- Reset values (async assert; all outputs and state, deassert synchronous to clk):
  - busy=0, done=0, out_valid=0, sop=0, eop=0, out_data=0, ram_chipselect=0, ram_address=0.
  - ram_clken=0 during reset, 1 after.
  - FIFO empty, state IDLE.
- FSM states and transitions:
  - IDLE -> READ on start with word_count != 0. Latch addr=base_addr and remaining=word_count. word_count > 1024 clamps to 1024.
  - start with word_count == 0: no reads, no stream output. done pulses the next cycle; busy stays 0.
  - READ: issue one read per cycle when remaining != 0 and (fifo_count + inflight) < FIFO_DEPTH.
    - An issue cycle sets ram_chipselect=1 and ram_address=addr.
    - On issue: addr increments mod 2^ADDR_W (1023 -> 0); remaining decrements.
  - READ -> DRAIN when the last read is issued.
  - DRAIN -> IDLE when the eop word is accepted (out_valid & out_ready & out_endofpacket). done pulses in that same transition cycle.
- Return pipeline:
  - inflight is a READ_LATENCY-deep valid shift register tagged with sop/eop.
  - ram_readdata is pushed to the FIFO exactly READ_LATENCY cycles after issue. The credit check guarantees the FIFO never overflows.
- Stream rules:
  - out_valid = FIFO non-empty. Pop on out_valid & out_ready.
  - out_data, sop and eop are held stable while out_valid & !out_ready.
  - sop is set on the first word only; eop on the last word only. word_count=1 gives sop=eop=1 on the same word.
- Latency and throughput:
  - Minimum latency is start -> first out_valid = 1 + READ_LATENCY + 1 cycles (3 by default).
  - Sustained 1 word/cycle with out_ready held high.
- Abort:
  - abort in READ/DRAIN stops issue, discards inflight data, and flushes the FIFO.
  - Next cycle: out_valid=0, done=1, busy=0, back in IDLE. The packet is truncated with no eop.
  - abort in IDLE is ignored. abort coincident with the eop pop counts as normal completion; done pulses once.
- Other boundary cases:
  - start while busy is ignored; base_addr/word_count changes while busy have no effect.
  - Reset mid-transfer discards everything; no done pulse.

Decomposition:
- Package demo_qsys_ram_streamer_pkg: state enum (IDLE, READ, DRAIN), ADDR_W/DATA_W defaults, MAX_WORDS=1024.
- One sub-module: demo_qsys_ram_stream_fifo.
  - Synchronous FIFO, width DATA_W+2 (data, sop, eop), depth FIFO_DEPTH.
  - Provides a count output and a flush input; same clk/reset_n.

Test Plan:
- RAM preloaded word[i]=i, start base=0 count=8, out_ready=1 -> data 0..7 on 8 consecutive cycles; sop on 0, eop on 7; first valid 3 cycles after start; done with eop accept.
- base=1020, count=6 -> data 1020,1021,1022,1023,0,1; ram_address wraps 1023->0.
- count=16, out_ready toggled 1 of 3 cycles -> all 16 words in order, no loss or duplication; data stable while stalled; chipselect never high when fifo_count+inflight=4.
- count=1 -> single word with sop=eop=1; count=0 -> no out_valid, done pulse next cycle, busy stays 0.
- count=100, out_ready=0, abort 10 cycles after start -> out_valid drops next cycle, done=1, busy=0; a following start base=5 count=2 streams 5,6 correctly.
- Assert reset_n low mid-transfer with out_valid=1 -> out_valid, busy and chipselect go 0 immediately (asynchronously); no done pulse after release.
